// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: mid-bit baud strobe generation, false-start / timeout
// recovery, and a small registered-output byte FIFO toward the consumer.
module uart_rx_ctrl #(
    parameter int CLK_DIV     = 868,
    parameter int FIFO_DEPTH  = 4,
    parameter int FRAME_TICKS = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       line_in,
    output logic       baud,
    output logic       rx_rst,
    input  logic [7:0] rx_data_in,
    input  logic       rx_done_in,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       overrun,
    output logic       frame_err,
    input  logic       clear_err,
    output logic       busy
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int TW = $clog2(FRAME_TICKS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(FRAME_TICKS - 1);
    localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, WAIT_HIGH} state_t;
    state_t r_state, w_state_nxt;

    logic          r_sync1, r_sync2, r_line_d;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_ticks;
    logic          r_rx_rst, r_frame_err, r_overrun;
    logic          w_fall, w_tick, w_false_start, w_timeout, w_abort;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_line_d <= 1'b1;
        end else begin
            r_sync1  <= line_in;
            r_sync2  <= r_sync1;
            r_line_d <= r_sync2;
        end
    end

    assign w_fall = r_line_d & ~r_sync2;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:      if (w_fall) w_state_nxt = RUN;
                RUN: begin
                    if (rx_done_in)         w_state_nxt = WAIT_HIGH;
                    else if (w_false_start) w_state_nxt = IDLE;
                    else if (w_timeout)     w_state_nxt = WAIT_HIGH;
                end
                WAIT_HIGH: if (r_sync2) w_state_nxt = IDLE;
                default:   w_state_nxt = IDLE;
            endcase
        end
    end

    // A completed byte outranks a false start or timeout seen in the same cycle.
    always_comb begin
        w_tick        = (r_state == RUN) && enable && (r_cnt == '0);
        w_false_start = w_tick && (r_ticks == '0) && r_sync2 && !rx_done_in;
        w_timeout     = w_tick && (r_ticks == LAST_TICK) && !rx_done_in;
        w_abort       = w_false_start || w_timeout;
        baud          = w_tick;
        busy          = (r_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_ticks <= '0;
        end else if (r_state == IDLE && w_fall && enable) begin
            r_cnt   <= HALF_LOAD;
            r_ticks <= '0;
        end else if (r_state == RUN) begin
            if (r_cnt == '0) begin
                r_cnt   <= FULL_LOAD;
                r_ticks <= r_ticks + TW'(1);
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_rst    <= 1'b1;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_rst <= !enable || w_abort;
            if (w_abort)        r_frame_err <= 1'b1;
            else if (clear_err) r_frame_err <= 1'b0;
        end
    end

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr, w_rptr_nxt;
    logic [AW:0]   r_count, w_count_nxt;
    logic [7:0]    r_data;
    logic          r_valid, w_pop, w_push, w_drop;

    always_comb begin
        w_pop      = r_valid && m_ready;
        w_push     = rx_done_in && ((r_count != DEPTH) || w_pop);
        w_drop     = rx_done_in && (r_count == DEPTH) && !w_pop;
        w_rptr_nxt = w_pop ? r_rptr + AW'(1) : r_rptr;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (AW + 1)'(1);
            2'b01:   w_count_nxt = r_count - (AW + 1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= rx_data_in;
    end

    // The new head is the incoming byte whenever it lands in the head slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            if (w_count_nxt != '0)
                r_data <= (w_push && (r_wptr == w_rptr_nxt)) ? rx_data_in : r_mem[w_rptr_nxt];
            if (w_drop)         r_overrun <= 1'b1;
            else if (clear_err) r_overrun <= 1'b0;
        end
    end

    assign rx_rst    = r_rx_rst;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign m_data    = r_data;
    assign m_valid   = r_valid;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl: the bench plays both the serial line and the
// byte receiver; FIFO behaviour is tracked by a queue model checked every cycle.
module tb_uart_rx_ctrl;
    localparam int DIV   = 16;
    localparam int DEPTH = 4;
    localparam int FT    = 12;

    logic       clk = 1'b0, rst = 1'b0, enable = 1'b0, line_in = 1'b1;
    logic       rx_done_in = 1'b0, m_ready = 1'b0, clear_err = 1'b0;
    logic [7:0] rx_data_in = 8'h00;
    logic       baud, rx_rst, m_valid, overrun, frame_err, busy;
    logic [7:0] m_data;

    int         n_tests = 0, n_fail = 0;
    logic [7:0] mq[$];
    logic       m_ovr = 1'b0;
    bit         chk_on = 1'b0, rdy_rand = 1'b0;
    bit         mdl_pop;

    uart_rx_ctrl #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .FRAME_TICKS(FT)) dut (
        .clk(clk), .rst(rst), .enable(enable), .line_in(line_in), .baud(baud),
        .rx_rst(rx_rst), .rx_data_in(rx_data_in), .rx_done_in(rx_done_in),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .overrun(overrun),
        .frame_err(frame_err), .clear_err(clear_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Byte-queue reference: a push into a full queue with no pop is lost and flags overrun.
    initial forever begin
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            m_ovr = 1'b0;
        end else begin
            mdl_pop = (mq.size() != 0) && m_ready;
            if (rx_done_in && mq.size() == DEPTH && !mdl_pop) begin
                m_ovr = 1'b1;
            end else begin
                if (clear_err) m_ovr = 1'b0;
                if (mdl_pop) void'(mq.pop_front());
                if (rx_done_in) mq.push_back(rx_data_in);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("m_valid", m_valid, 32'(mq.size() != 0));
            if (mq.size() != 0) chk("m_data", m_data, mq[0]);
            chk("overrun", overrun, m_ovr);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        if (rdy_rand) m_ready = 1'($urandom_range(0, 1));
    endtask

    // Drive a full 10-bit frame; receiver side samples data on strobes 1..8, completes on 9.
    task automatic frame(input logic [7:0] b);
        logic [9:0] bits;
        logic [7:0] cap;
        int k, extra, done_n;
        bits = {1'b1, b, 1'b0};
        k = 0; extra = 0; cap = 8'h00; done_n = -10;
        for (int n = 0; n < 10 * DIV + 40; n++) begin
            step();
            rx_done_in = 1'b0;
            if (n == done_n + 1) chk("valid_after_done", m_valid, 1);
            if (baud) begin
                if (k < 10) begin
                    chk("strobe_pos", n, 2 + DIV / 2 + DIV * k);
                    if (k >= 1 && k <= 8) cap[k-1] = line_in;
                    if (k == 9) begin
                        rx_data_in = cap;
                        rx_done_in = 1'b1;
                        done_n     = n;
                    end
                    k++;
                end else begin
                    extra++;
                end
            end
            line_in = (n < 10 * DIV) ? bits[n/DIV] : 1'b1;
        end
        chk("strobe_cnt", k, 10);
        chk("extra_strobes", extra, 0);
        chk("rx_byte", cap, b);
        chk("frame_err_ok", frame_err, 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic push_byte(input logic [7:0] b);
        step();
        rx_data_in = b;
        rx_done_in = 1'b1;
        step();
        rx_done_in = 1'b0;
    endtask

    task automatic expect_drain(input string tag, input logic [7:0] exp[$]);
        logic [7:0] got[$];
        for (int i = 0; i < 3 * DEPTH; i++) begin
            step();
            if (m_valid) got.push_back(m_data);
            m_ready = 1'b1;
        end
        m_ready = 1'b0;
        chk({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) chk(tag, got[i], exp[i]);
    endtask

    task automatic clear_flags();
        step(); clear_err = 1'b1;
        step(); clear_err = 1'b0;
        step();
        chk("clr_frame_err", frame_err, 0);
    endtask

    initial begin
        logic [7:0] ex[$];
        int nb, first;

        rst = 1'b0; enable = 1'b0;
        repeat (3) step();
        chk_on = 1'b1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_baud", baud, 0);
        chk("rst_rx_rst", rx_rst, 1);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1; enable = 1'b1;
        repeat (2) step();
        chk("rx_rst_release", rx_rst, 0);

        // Valid frame 0xA5, consumer stalled
        frame(8'hA5);
        chk("a5_valid", m_valid, 1);
        chk("a5_data", m_data, 8'hA5);
        ex = '{8'hA5};
        expect_drain("drain_a5", ex);

        // 3-cycle low glitch: one strobe, then abort
        nb = 0; first = -1;
        for (int n = 0; n < 60; n++) begin
            step();
            if (baud) begin
                if (first < 0) first = n;
                nb++;
            end
            if (n == 10) chk("glitch_rxrst_pre", rx_rst, 0);
            if (n == 11) begin
                chk("glitch_rxrst", rx_rst, 1);
                chk("glitch_ferr", frame_err, 1);
                chk("glitch_busy", busy, 0);
            end
            if (n == 12) chk("glitch_rxrst_end", rx_rst, 0);
            line_in = (n < 3) ? 1'b0 : 1'b1;
        end
        chk("glitch_first", first, 2 + DIV / 2);
        chk("glitch_nstrobe", nb, 1);
        chk("glitch_empty", m_valid, 0);
        clear_flags();

        // Overrun: five pushes into a four-deep FIFO
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        step();
        chk("ovr_set", overrun, 1);
        ex = '{8'h01, 8'h02, 8'h03, 8'h04};
        expect_drain("drain_ovr", ex);
        clear_flags();
        chk("ovr_clr", overrun, 0);

        // Full FIFO: push and pop together
        for (int i = 1; i <= 4; i++) push_byte(8'(8'h11 * i));
        step();
        rx_data_in = 8'h55; rx_done_in = 1'b1; m_ready = 1'b1;
        step();
        rx_done_in = 1'b0; m_ready = 1'b0;
        step();
        chk("full_pp_ovr", overrun, 0);
        ex = '{8'h22, 8'h33, 8'h44, 8'h55};
        expect_drain("drain_full_pp", ex);

        // One entry: push and pop together, head moves to the new byte
        push_byte(8'h66);
        step();
        rx_data_in = 8'h77; rx_done_in = 1'b1; m_ready = 1'b1;
        step();
        rx_done_in = 1'b0; m_ready = 1'b0;
        ex = '{8'h77};
        expect_drain("drain_one_pp", ex);

        // Stuck-low line: timeout after FT strobes, then wait for the line to rise
        nb = 0;
        for (int n = 0; n < 260; n++) begin
            step();
            if (baud) begin
                chk("to_strobe_pos", n, 2 + DIV / 2 + DIV * nb);
                nb++;
            end
            if (n == 2 + DIV / 2 + DIV * (FT - 1) + 1) begin
                chk("to_rxrst", rx_rst, 1);
                chk("to_ferr", frame_err, 1);
                chk("to_busy", busy, 1);
            end
            if (n == 249) chk("to_wait_high", busy, 1);
            line_in = (n < 250) ? 1'b0 : 1'b1;
        end
        chk("to_nstrobe", nb, FT);
        chk("to_idle", busy, 0);

        // Reset mid-frame with two bytes buffered and frame_err still set
        push_byte(8'hAA);
        push_byte(8'hBB);
        step(); line_in = 1'b0;
        repeat (30) step();
        rst = 1'b0; line_in = 1'b1;
        step();
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_baud", baud, 0);
        chk("mid_rst_rxrst", rx_rst, 1);
        chk("mid_rst_ferr", frame_err, 0);
        chk("mid_rst_ovr", overrun, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b1;
        repeat (3) step();

        // Disable mid-frame: strobes stop, buffered bytes survive
        push_byte(8'hC1);
        push_byte(8'hC2);
        step(); line_in = 1'b0;
        repeat (30) step();
        enable = 1'b0;
        nb = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (baud) nb++;
            if (n == 20) line_in = 1'b1;
        end
        chk("dis_nstrobe", nb, 0);
        chk("dis_rxrst", rx_rst, 1);
        chk("dis_busy", busy, 0);
        enable = 1'b1;
        repeat (3) step();
        ex = '{8'hC1, 8'hC2};
        expect_drain("drain_dis", ex);

        // Random frames with a random consumer
        rdy_rand = 1'b1;
        for (int i = 0; i < 4; i++) frame(8'($urandom));
        // Random push/pop/clear traffic on an idle line
        for (int i = 0; i < 300; i++) begin
            step();
            rx_done_in = ($urandom_range(0, 2) == 0);
            rx_data_in = 8'($urandom);
            clear_err  = ($urandom_range(0, 15) == 0);
        end
        step();
        rx_done_in = 1'b0; clear_err = 1'b0; rdy_rand = 1'b0; m_ready = 1'b1;
        repeat (2 * DEPTH) step();
        chk("final_empty", m_valid, 0);
        m_ready = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
